// File: rtl/array_count_pkg.sv
// array_count_pkg: comparison modes, scan states and mode width shared by the array scan engine
package array_count_pkg;
  localparam int ModeW = 3;
  typedef enum logic [ModeW-1:0] {CMP_LT, CMP_LE, CMP_EQ, CMP_NE, CMP_GT, CMP_GE} cmp_e;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;
endpackage

// File: rtl/array_compare.sv
// array_compare: combinational unsigned element-vs-key compare; in element/key/mode, out match (modes 6,7 never match)
module array_compare
  import array_count_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0]     element,
  input  logic [W-1:0]     key,
  input  logic [ModeW-1:0] mode,
  output logic             match
);
  always_comb
    match = mode == CMP_LT ? element < key :
            mode == CMP_LE ? element <= key :
            mode == CMP_EQ ? element == key :
            mode == CMP_NE ? element != key :
            mode == CMP_GT ? element > key :
            mode == CMP_GE ? element >= key : 1'b0;
endmodule

// File: rtl/array_count_scan.sv
// array_count_scan: counts heap array elements matching mode vs key; in clock/reset/start/array/size/key/mode/mem_rdata, out mem_rd/mem_addr/busy/done/count, plus first when ARRAY_COUNT_FIRST_EN
module array_count_scan
  import array_count_pkg::*;
#(
  parameter int MemoryElementWidth = 12,
  parameter int NArea = 4,
  parameter int NArrays = 1,
  parameter int AW = $clog2(NArrays * NArea),
  parameter int CW = $clog2(NArea + 1),
  parameter int ArW = (NArrays > 1) ? $clog2(NArrays) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ArW-1:0]                array,
  input  logic [MemoryElementWidth-1:0] size,
  input  logic [MemoryElementWidth-1:0] key,
  input  logic [ModeW-1:0]              mode,
  output logic                          mem_rd,
  output logic [AW-1:0]                 mem_addr,
  input  logic [MemoryElementWidth-1:0] mem_rdata,
  output logic                          busy,
  output logic                          done,
  output logic [CW-1:0]                 count
`ifdef ARRAY_COUNT_FIRST_EN
  ,
  output logic [CW-1:0]                 first
`endif
);
  state_e state, state_n;
  logic [ArW-1:0] arr_q;
  logic [MemoryElementWidth-1:0] key_q;
  logic [ModeW-1:0] mode_q;
  logic [CW-1:0] size_q, size_c, idx;
  logic rd_q, match, accept;
  assign accept = start && state != S_SCAN;
  assign size_c = (size > MemoryElementWidth'(NArea)) ? CW'(NArea) : CW'(size);
  array_compare #(.W(MemoryElementWidth)) u_cmp (
    .element(mem_rdata),
    .key(key_q),
    .mode(mode_q),
    .match(match)
  );
  always_ff @(posedge clock)
    state <= reset ? S_IDLE : state_n;
  always_comb begin
    busy = state == S_SCAN;
    done = state == S_DONE;
    mem_rd = busy && idx != size_q;
    mem_addr = mem_rd ? AW'(int'(arr_q) * NArea + int'(idx)) : '0;
    state_n = accept ? S_SCAN : done ? S_IDLE : (busy && idx == size_q) ? S_DONE : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      arr_q <= '0;
      key_q <= '0;
      mode_q <= '0;
      size_q <= '0;
      idx <= '0;
      rd_q <= 1'b0;
      count <= '0;
    end else begin
      rd_q <= mem_rd;
      if (accept) begin
        arr_q <= array;
        key_q <= key;
        mode_q <= mode;
        size_q <= size_c;
        idx <= '0;
        count <= '0;
      end else begin
        if (mem_rd) idx <= idx + 1'b1;
        if (rd_q && match) count <= count + 1'b1;
      end
    end
  end
`ifdef ARRAY_COUNT_FIRST_EN
  always_ff @(posedge clock) begin
    if (reset) first <= '0;
    else if (accept) first <= size_c;
    else if (rd_q && match && count == '0) first <= idx - 1'b1;
  end
`endif
endmodule

// File: tb/tb_array_count_scan.sv
// tb_array_count_scan: randomized and directed self-checking bench for array_count_scan against a loop-based reference
module tb_array_count_scan;
  logic clock = 1'b0;
  logic reset, start;
  logic [0:0] array;
  logic [11:0] size, key, mem_rdata;
  logic [2:0] mode, mem_addr, count;
  logic mem_rd, busy, done;
`ifdef ARRAY_COUNT_FIRST_EN
  logic [2:0] first;
`endif
  logic [11:0] heap [8];
  int total = 0, bad = 0;
  always #5 clock = ~clock;
  array_count_scan #(.MemoryElementWidth(12), .NArea(4), .NArrays(2)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .array(array),
    .size(size),
    .key(key),
    .mode(mode),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .busy(busy),
    .done(done),
    .count(count)
`ifdef ARRAY_COUNT_FIRST_EN
    ,
    .first(first)
`endif
  );
  always @(posedge clock) mem_rdata <= mem_rd ? heap[mem_addr] : 12'($urandom);
  function automatic bit hit(input logic [11:0] e, input logic [11:0] k, input int m);
    case (m)
      0: return e < k;
      1: return e <= k;
      2: return e == k;
      3: return e != k;
      4: return e > k;
      5: return e >= k;
      default: return 1'b0;
    endcase
  endfunction
  function automatic void ref_scan(input int a, input int s, input logic [11:0] k, input int m,
                                   output int cnt, output int fst);
    int n = s > 4 ? 4 : s;
    cnt = 0;
    fst = n;
    for (int i = 0; i < n; i++)
      if (hit(heap[a * 4 + i], k, m)) begin
        if (cnt == 0) fst = i;
        cnt++;
      end
  endfunction
  task automatic scan(input int a, input int s, input int k, input int m,
                      output int lat, output int nrd, output bit ok);
    nrd = 0;
    ok = 1'b1;
    lat = 0;
    array = 1'(a);
    size = 12'(s);
    key = 12'(k);
    mode = 3'(m);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (mem_rd) begin
        if (mem_addr !== 3'(a * 4 + nrd) || c != nrd + 1) ok = 1'b0;
        nrd++;
      end
      if (done) begin
        lat = c;
        if (busy) ok = 1'b0;
        break;
      end
      if (!busy) ok = 1'b0;
      @(negedge clock);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    total += 6;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b want=0", mem_rd); end
    if (mem_addr !== 3'd0) begin bad++; $display("FAIL reset_mem_addr got=%0d want=0", mem_addr); end
    if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
`ifdef ARRAY_COUNT_FIRST_EN
    if (first !== 3'd0) begin bad++; $display("FAIL reset_first got=%0d want=0", first); end
`else
    if (count !== 3'd0) begin bad++; $display("FAIL reset_count2 got=%0d want=0", count); end
`endif
    reset = 1'b0;
    @(negedge clock);
  endtask
  task automatic test_plan();
    int ta[7] = '{0, 0, 0, 0, 0, 1, 1};
    int ts[7] = '{3, 3, 3, 0, 9, 3, 3};
    int tk[7] = '{20, 20, 25, 20, 35, 5, 5};
    int tm[7] = '{0, 5, 2, 1, 0, 6, 2};
    int tc[7] = '{1, 2, 0, 0, 3, 0, 3};
    int tf[7] = '{0, 1, 3, 0, 0, 3, 0};
    int lat, nrd, en;
    bit ok;
    heap[0] = 12'd10; heap[1] = 12'd20; heap[2] = 12'd30; heap[3] = 12'd40;
    heap[4] = 12'd5; heap[5] = 12'd5; heap[6] = 12'd5; heap[7] = 12'd9;
    for (int t = 0; t < 7; t++) begin
      scan(ta[t], ts[t], tk[t], tm[t], lat, nrd, ok);
      en = ts[t] > 4 ? 4 : ts[t];
      total += 4;
      if (lat != en + 2) begin bad++; $display("FAIL plan%0d_latency got=%0d want=%0d", t, lat, en + 2); end
      if (nrd != en) begin bad++; $display("FAIL plan%0d_reads got=%0d want=%0d", t, nrd, en); end
      if (!ok) begin bad++; $display("FAIL plan%0d_timing got=0 want=1", t); end
      if (count !== 3'(tc[t])) begin bad++; $display("FAIL plan%0d_count got=%0d want=%0d", t, count, tc[t]); end
`ifdef ARRAY_COUNT_FIRST_EN
      total++;
      if (first !== 3'(tf[t])) begin bad++; $display("FAIL plan%0d_first got=%0d want=%0d", t, first, tf[t]); end
`endif
    end
  endtask
  task automatic test_random();
    int a, s, k, m, lat, nrd, en, ec, ef;
    bit ok;
    for (int i = 0; i < 8; i++) heap[i] = 12'($urandom_range(15));
    for (int t = 0; t < 40; t++) begin
      heap[$urandom_range(7)] = 12'($urandom_range(15));
      a = int'($urandom_range(1));
      s = int'($urandom_range(6));
      k = int'($urandom_range(15));
      m = int'($urandom_range(7));
      ref_scan(a, s, 12'(k), m, ec, ef);
      scan(a, s, k, m, lat, nrd, ok);
      en = s > 4 ? 4 : s;
      total += 4;
      if (lat != en + 2) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", t, lat, en + 2); end
      if (nrd != en) begin bad++; $display("FAIL rnd%0d_reads got=%0d want=%0d", t, nrd, en); end
      if (!ok) begin bad++; $display("FAIL rnd%0d_timing got=0 want=1", t); end
      if (count !== 3'(ec)) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", t, count, ec); end
`ifdef ARRAY_COUNT_FIRST_EN
      total++;
      if (first !== 3'(ef)) begin bad++; $display("FAIL rnd%0d_first got=%0d want=%0d", t, first, ef); end
`endif
      if ($urandom_range(1) == 1) begin
        @(negedge clock);
        total += 2;
        if (done !== 1'b0) begin bad++; $display("FAIL rnd%0d_done_pulse got=%b want=0", t, done); end
        if (count !== 3'(ec)) begin bad++; $display("FAIL rnd%0d_count_hold got=%0d want=%0d", t, count, ec); end
      end
    end
  endtask
  task automatic test_back_to_back();
    int c, d1, d2, ec1, ef1, ec2, ef2;
    bit quiet;
    ref_scan(1, 3, 12'd3, 4, ec1, ef1);
    ref_scan(0, 2, 12'd8, 1, ec2, ef2);
    array = 1'b1; size = 12'd3; key = 12'd3; mode = 3'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    c = 1;
    @(negedge clock);
    c = 2;
    array = 1'b0; size = 12'd1; key = 12'd0; mode = 3'd3; start = 1'b1;
    @(negedge clock);
    c = 3;
    start = 1'b0;
    d1 = 0;
    while (d1 == 0 && c < 40) begin
      if (done) d1 = c;
      else begin @(negedge clock); c++; end
    end
    total += 2;
    if (d1 != 5) begin bad++; $display("FAIL b2b_first_done got=%0d want=5", d1); end
    if (count !== 3'(ec1)) begin bad++; $display("FAIL b2b_first_count got=%0d want=%0d", count, ec1); end
    array = 1'b0; size = 12'd2; key = 12'd8; mode = 3'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    c = 1;
    d2 = 0;
    while (d2 == 0 && c < 40) begin
      if (done) d2 = c;
      else begin @(negedge clock); c++; end
    end
    total += 2;
    if (d2 != 4) begin bad++; $display("FAIL b2b_gap got=%0d want=4", d2); end
    if (count !== 3'(ec2)) begin bad++; $display("FAIL b2b_second_count got=%0d want=%0d", count, ec2); end
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (busy || done) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL b2b_no_queue got=0 want=1"); end
  endtask
  task automatic test_reset_mid();
    bit quiet;
    array = 1'b0; size = 12'd3; key = 12'd4095; mode = 3'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    if (mem_rd !== 1'b0) begin bad++; $display("FAIL midrst_mem_rd got=%b want=0", mem_rd); end
    if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    if (count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", count); end
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (busy || done || mem_rd) quiet = 1'b0;
    end
    total += 2;
    if (!quiet) begin bad++; $display("FAIL midrst_abandon got=0 want=1"); end
    if (count !== 3'd0) begin bad++; $display("FAIL midrst_count_after got=%0d want=0", count); end
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; array = '0; size = '0; key = '0; mode = '0;
    for (int i = 0; i < 8; i++) heap[i] = '0;
    repeat (2) @(negedge clock);
    test_reset();
    test_plan();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
